// File: rtl/xload_bus_master.sv
// Byte-stream to native memory bus initiator: decodes framed read/write commands,
// issues one 32-bit bus transaction per frame and streams back status and read data.
module xload_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_W           = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [7:0] CMD_WR = 8'hA5;
   localparam logic [7:0] CMD_RD = 8'h5A;
   localparam logic [7:0] ST_OK  = 8'h00;
   localparam logic [7:0] ST_TO  = 8'hEE;
   localparam logic [7:0] ST_BAD = 8'hFF;
   localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP, S_RDATA
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            op_wr_q, op_wr_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            rx_ready_q, tx_valid_q, mem_valid_q, busy_q;
   logic            rx_fire, tx_fire;

   assign rx_fire = rx_valid && rx_ready_q;
   assign tx_fire = tx_valid_q && tx_ready;

   // Next-state and datapath update; tx_data holds the status byte while in RESP.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_wr_d   = op_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      wstrb_d   = wstrb_q;
      to_d      = to_q;
      tx_data_d = tx_data_q;
      case (state_q)
         S_IDLE: begin
            if (rx_fire) begin
               if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                  op_wr_d = (rx_data == CMD_WR);
                  cnt_d   = 2'd0;
                  state_d = S_ADDR;
               end else begin
                  tx_data_d = ST_BAD;
                  state_d   = S_RESP;
               end
            end
         end
         S_ADDR: begin
            if (rx_fire) begin
               addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
               addr_d[1:0] = 2'b00;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = op_wr_q ? S_DATA : S_BUS;
            end
         end
         S_DATA: begin
            if (rx_fire) begin
               wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_BUS;
            end
         end
         S_BUS: begin
            // A completion in the final timeout cycle still counts as success.
            if (mem_ready) begin
               rdata_d   = mem_rdata;
               tx_data_d = ST_OK;
               state_d   = S_RESP;
            end else if (TO_EN && to_q == TO_LAST) begin
               tx_data_d = ST_TO;
               state_d   = S_RESP;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_RESP: begin
            if (tx_fire) begin
               if (!op_wr_q && tx_data_q == ST_OK) begin
                  cnt_d     = 2'd0;
                  tx_data_d = rdata_q[7:0];
                  state_d   = S_RDATA;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_RDATA: begin
            if (tx_fire) begin
               cnt_d     = cnt_q + 2'd1;
               tx_data_d = rdata_q[{cnt_d, 3'b000} +: 8];
               if (cnt_q == 2'd3) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_BUS && state_q != S_BUS) begin
         to_d    = '0;
         wstrb_d = op_wr_q ? 4'hF : 4'h0;
      end
   end

   // Handshake outputs are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         op_wr_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         wstrb_q     <= '0;
         to_q        <= '0;
         tx_data_q   <= '0;
         rx_ready_q  <= 1'b1;
         tx_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_wr_q     <= op_wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         wstrb_q     <= wstrb_d;
         to_q        <= to_d;
         tx_data_q   <= tx_data_d;
         rx_ready_q  <= (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
         tx_valid_q  <= (state_d == S_RESP) || (state_d == S_RDATA);
         mem_valid_q <= (state_d == S_BUS);
         busy_q      <= (state_d != S_IDLE);
      end
   end

   assign rx_ready  = rx_ready_q;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign mem_valid = mem_valid_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_xload_bus_master.sv
// Randomized bench for xload_bus_master: frames are scored against a transaction-level
// model of the command protocol and a behavioural memory responder.
module tb_xload_bus_master;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy;

   always #5 clk = ~clk;

   xload_bus_master #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
      .clk(clk), .resetn(resetn),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   int n_cmp = 0;
   int n_err = 0;

   // responder configuration and observations
   bit          resp_on = 1'b1;
   int          resp_lat = 1;
   bit          linger = 1'b0;
   int          valid_cycles = 0;
   int          hs_count = 0;
   logic [31:0] hs_addr, hs_wdata, va_addr;
   logic [3:0]  hs_wstrb;
   logic [31:0] bus_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   // scenario data
   logic [7:0]  frame[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_got[$];
   bit          exp_bus, exp_wr;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;
   int          exp_vcycles;

   function automatic logic [31:0] fill_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] bus_read(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : fill_word(a);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill_word(a);
   endfunction

   // Memory responder: ready after resp_lat wait cycles, optionally lingering one cycle.
   initial begin
      logic [31:0] pa, pw;
      logic [3:0]  ps;
      bit          pv, lingered;
      int          run;
      mem_ready = 1'b0; mem_rdata = '0; pv = 0; run = 0; lingered = 0;
      pa = '0; pw = '0; ps = '0;
      forever begin
         @(negedge clk);
         if (mem_valid === 1'b1) begin
            valid_cycles++;
            va_addr = mem_addr;
            n_cmp++;
            if (mem_addr[1:0] !== 2'b00 || (pv && (mem_addr !== pa || mem_wdata !== pw || mem_wstrb !== ps))) begin
               n_err++;
               $display("FAIL req_stable: addr=%h wdata=%h wstrb=%h, expected addr=%h wdata=%h wstrb=%h, aligned",
                        mem_addr, mem_wdata, mem_wstrb, pa, pw, ps);
            end
            pv = 1; pa = mem_addr; pw = mem_wdata; ps = mem_wstrb;
            if (mem_ready) begin
               hs_count++;
               hs_addr = mem_addr; hs_wdata = mem_wdata; hs_wstrb = mem_wstrb;
               if (mem_wstrb === 4'hF) bus_mem[mem_addr] = mem_wdata;
            end
         end else begin
            pv = 0;
         end
         @(posedge clk);
         #1;
         if (mem_valid === 1'b1) run++; else run = 0;
         if (mem_valid === 1'b1 && resp_on && run > resp_lat) begin
            mem_ready = 1'b1;
            mem_rdata = bus_read(mem_addr);
            lingered = 0;
         end else if (mem_valid !== 1'b1 && mem_ready && linger && !lingered) begin
            mem_ready = 1'b1;
            mem_rdata = $urandom;
            lingered = 1;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            lingered = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   // Transaction-level expectation for the frame currently in `frame`.
   task automatic model_frame();
      logic [31:0] d;
      exp_q = {};
      exp_bus = 0; exp_vcycles = 0; exp_wr = 0;
      if (frame[0] != 8'hA5 && frame[0] != 8'h5A) begin
         exp_q.push_back(8'hFF);
         return;
      end
      exp_wr    = (frame[0] == 8'hA5);
      exp_bus   = 1;
      exp_addr  = {frame[4], frame[3], frame[2], frame[1]} & 32'hFFFF_FFFC;
      exp_wstrb = exp_wr ? 4'hF : 4'h0;
      exp_wdata = exp_wr ? {frame[8], frame[7], frame[6], frame[5]} : 32'h0;
      if (!resp_on) begin
         exp_q.push_back(8'hEE);
         exp_vcycles = TO;
      end else begin
         exp_vcycles = resp_lat + 1;
         exp_q.push_back(8'h00);
         if (exp_wr) begin
            ref_mem[exp_addr] = exp_wdata;
         end else begin
            d = ref_read(exp_addr);
            for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
         end
      end
   endtask

   task automatic mk_wr(input logic [31:0] a, input logic [31:0] d);
      frame = {8'hA5, a[7:0], a[15:8], a[23:16], a[31:24], d[7:0], d[15:8], d[23:16], d[31:24]};
   endtask

   task automatic mk_rd(input logic [31:0] a);
      frame = {8'h5A, a[7:0], a[15:8], a[23:16], a[31:24]};
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      ok = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      for (int w = 0; w < 60; w++) begin
         @(negedge clk);
         if (rx_ready === 1'b1) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic recv_bytes(input int n, output bit ok);
      logic [7:0] held;
      bit pend;
      rx_got = {};
      pend = 0;
      held = '0;
      for (int cyc = 0; cyc < 300 && rx_got.size() < n; cyc++) begin
         @(negedge clk);
         if (pend) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== held) begin
               n_err++;
               $display("FAIL tx_hold: valid=%b data=%h, expected valid=1 data=%h", tx_valid, tx_data, held);
            end
         end
         tx_ready = ($urandom_range(0, 2) != 0);
         if (tx_valid === 1'b1 && tx_ready) begin
            rx_got.push_back(tx_data);
            pend = 0;
         end else if (tx_valid === 1'b1) begin
            pend = 1;
            held = tx_data;
         end
      end
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      ok = (rx_got.size() == n);
   endtask

   task automatic run_frame(input string tag);
      bit ok;
      int hs0;
      model_frame();
      valid_cycles = 0;
      hs0 = hs_count;
      foreach (frame[i]) begin
         send_byte(frame[i], ok);
         n_cmp++;
         if (!ok) begin
            n_err++;
            $display("FAIL %s rx_accept: byte %0d not consumed, expected rx_ready", tag, i);
         end
      end
      n_cmp++;
      if (mem_valid !== exp_bus) begin
         n_err++;
         $display("FAIL %s bus_start: mem_valid=%b after last byte, expected %b", tag, mem_valid, exp_bus);
      end
      recv_bytes(exp_q.size(), ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s tx_count: got %0d bytes, expected %0d", tag, rx_got.size(), exp_q.size());
      end
      for (int i = 0; i < rx_got.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (rx_got[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL %s tx_byte[%0d]: got %h, expected %h", tag, i, rx_got[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle: busy=%b tx_valid=%b, expected 0 0", tag, busy, tx_valid);
      end
      n_cmp++;
      if (valid_cycles != exp_vcycles) begin
         n_err++;
         $display("FAIL %s valid_len: mem_valid cycles=%0d, expected %0d", tag, valid_cycles, exp_vcycles);
      end
      if (exp_bus) begin
         n_cmp++;
         if (va_addr !== exp_addr) begin
            n_err++;
            $display("FAIL %s bus_addr: got %h, expected %h", tag, va_addr, exp_addr);
         end
         n_cmp++;
         if (resp_on && (hs_count != hs0 + 1 || hs_addr !== exp_addr || hs_wstrb !== exp_wstrb ||
                         (exp_wr && hs_wdata !== exp_wdata))) begin
            n_err++;
            $display("FAIL %s bus_hs: n=%0d addr=%h wstrb=%h wdata=%h, expected n=1 addr=%h wstrb=%h wdata=%h",
                     tag, hs_count - hs0, hs_addr, hs_wstrb, hs_wdata, exp_addr, exp_wstrb, exp_wdata);
         end else if (!resp_on && hs_count != hs0) begin
            n_err++;
            $display("FAIL %s bus_hs: %0d handshakes, expected 0", tag, hs_count - hs0);
         end
      end
   endtask

   task automatic pulse_reset(input string tag);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      n_cmp++;
      if (mem_valid !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s reset_edge: mem_valid=%b tx_valid=%b busy=%b rx_ready=%b, expected 0 0 0 1",
                  tag, mem_valid, tx_valid, busy, rx_ready);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_stream: rx_ready=%b tx_valid=%b tx_data=%h busy=%b, expected 1 0 00 0",
                  rx_ready, tx_valid, tx_data, busy);
      end
      n_cmp++;
      if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
         n_err++;
         $display("FAIL reset_bus: valid=%b addr=%h wdata=%h wstrb=%h, expected all zero",
                  mem_valid, mem_addr, mem_wdata, mem_wstrb);
      end
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic test_write();
      resp_on = 1; resp_lat = 1; linger = 0;
      frame = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_frame("write");
   endtask

   task automatic test_read();
      resp_on = 1; resp_lat = 2; linger = 0;
      bus_mem[32'h0010_0004] = 32'h1234_5678;
      ref_mem[32'h0010_0004] = 32'h1234_5678;
      frame = {8'h5A, 8'h04, 8'h00, 8'h10, 8'h00};
      run_frame("read");
   endtask

   task automatic test_timeout();
      resp_on = 0; linger = 0;
      mk_rd(32'h0200_0003);
      run_frame("timeout");
      resp_on = 1;
   endtask

   task automatic test_unknown();
      resp_on = 1; resp_lat = 0; linger = 0;
      frame = {8'h00};
      run_frame("unknown");
      mk_wr(32'h0000_0040, 32'hCAFE_F00D);
      run_frame("after_unknown");
      mk_rd(32'h0000_0040);
      run_frame("after_unknown_rd");
   endtask

   task automatic test_reset_mid();
      bit ok;
      resp_on = 0; linger = 0;
      mk_rd(32'h0000_0200);
      foreach (frame[i]) send_byte(frame[i], ok);
      repeat (2) @(posedge clk);
      #1;
      pulse_reset("rst_bus");
      frame = {8'hA5, 8'h10, 8'h20};
      foreach (frame[i]) send_byte(frame[i], ok);
      pulse_reset("rst_addr");
      repeat (TO + 4) begin
         @(negedge clk);
         n_cmp++;
         if (tx_valid !== 1'b0 || mem_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_quiet: tx_valid=%b mem_valid=%b, expected 0 0", tx_valid, mem_valid);
         end
      end
      @(posedge clk);
      #1;
      resp_on = 1; resp_lat = 1;
      mk_wr(32'h0000_0300, 32'h0BAD_CAFE);
      run_frame("after_reset");
   endtask

   task automatic test_back_to_back();
      resp_on = 1; resp_lat = 0; linger = 1;
      mk_wr(32'h0000_0500, 32'h5555_AAAA);
      run_frame("linger_wr");
      mk_rd(32'h0000_0500);
      run_frame("linger_rd");
      resp_lat = 1;
      mk_rd(32'h0000_0504);
      run_frame("linger_rd2");
      linger = 0;
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      logic [7:0]  c;
      int          kind;
      for (int n = 0; n < 30; n++) begin
         kind     = $urandom_range(0, 9);
         resp_lat = $urandom_range(0, 3);
         linger   = $urandom_range(0, 1);
         resp_on  = (kind != 9);
         a = {22'h0, 2'($urandom_range(0, 3)), 6'($urandom), 2'($urandom)};
         d = $urandom;
         if (kind == 8) begin
            c = 8'($urandom);
            if (c == 8'hA5 || c == 8'h5A) c = 8'h3C;
            frame = {c};
         end else if (kind <= 3 || (kind == 9 && a[2])) begin
            mk_wr(a, d);
         end else begin
            mk_rd(a);
         end
         run_frame($sformatf("rand%0d", n));
      end
      resp_on = 1; linger = 0;
   endtask

   initial begin
      resetn = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_unknown();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
